// File: rtl/ora_misr_pkg.sv
// Shared definitions for the LBIST output response analyser: FSM encoding
// and default MISR constants.
package ora_misr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMPRESS = 2'd1,
    ST_COMPARE  = 2'd2,
    ST_DONE     = 2'd3
  } ora_state_e;

  localparam int          DEF_BITS   = 4;
  localparam logic [31:0] DEF_SEED   = 32'h0;
  localparam logic [31:0] DEF_GOLDEN = 32'h4;

  // Default feedback taps per signature width.
  function automatic logic [31:0] default_poly(input int bits);
    case (bits)
      4:       return 32'h0000_0009;
      5:       return 32'h0000_0012;
      6:       return 32'h0000_0021;
      7:       return 32'h0000_0041;
      8:       return 32'h0000_008E;
      default: return 32'h1 | (32'h1 << (bits - 1));
    endcase
  endfunction

  function automatic int default_max_pat(input int bits);
    return (1 << bits) + 1;
  endfunction

endpackage

// File: rtl/ora_misr_if.sv
// Control, response and status bundle between the LBIST controller side
// (master) and the response analyser (slave).
interface ora_misr_if #(
  parameter int BITS  = 4,
  parameter int CNT_W = BITS + 2
);
  logic             start;
  logic [BITS-1:0]  resp;
  logic             resp_valid;
  logic             end_in;
  logic [BITS-1:0]  signature;
  logic [CNT_W-1:0] pat_count;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;

  modport master (
    output start, resp, resp_valid, end_in,
    input  signature, pat_count, busy, done, pass, timeout
  );

  modport slave (
    input  start, resp, resp_valid, end_in,
    output signature, pat_count, busy, done, pass, timeout
  );
endinterface

// File: rtl/ora_misr_core.sv
// Multiple-input signature register: shift right with XOR feedback into the MSB,
// folding in one response word per enabled cycle.
module misr_core #(
  parameter int              BITS = 4,
  parameter logic [BITS-1:0] POLY = BITS'(4'b1001),
  parameter logic [BITS-1:0] SEED = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [BITS-1:0] din,
  output logic [BITS-1:0] sig
);

  logic [BITS-1:0] sig_q;
  logic [BITS-1:0] sig_d;
  logic            fb;

  // load wins over en so a restart never mixes in the previous run's state.
  always_comb begin
    fb    = ^(sig_q & POLY);
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {fb, sig_q[BITS-1:1]} ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/ora_misr.sv
// LBIST output response analyser: compresses CUT responses into a MISR,
// closes on the rpg END pulse (or a pattern-count timeout) and grades the result.
module ora_misr
  import ora_misr_pkg::*;
#(
  parameter int              BITS    = DEF_BITS,
  parameter logic [BITS-1:0] POLY    = BITS'(default_poly(BITS)),
  parameter logic [BITS-1:0] SEED    = BITS'(DEF_SEED),
  parameter logic [BITS-1:0] GOLDEN  = BITS'(DEF_GOLDEN),
  parameter int              MAX_PAT = default_max_pat(BITS),
  parameter int              CNT_W   = BITS + 2
) (
  input  logic           clk,
  input  logic           rst,
  ora_misr_if.slave      bus
);

  ora_state_e       state_q, state_d;
  logic [CNT_W-1:0] pat_count_q, pat_count_d;
  logic             armed_q, armed_d;
  logic             to_flag_q, to_flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;

  logic             sig_load;
  logic             sig_en;
  logic [BITS-1:0]  sig;
  logic [CNT_W-1:0] pat_inc;
  logic [CNT_W-1:0] pat_next;
  logic             max_hit;

  misr_core #(
    .BITS (BITS),
    .POLY (POLY),
    .SEED (SEED)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (sig_load),
    .en   (sig_en),
    .din  (bus.resp),
    .sig  (sig)
  );

  assign pat_inc  = (pat_count_q == {CNT_W{1'b1}}) ? pat_count_q : pat_count_q + CNT_W'(1);
  assign pat_next = bus.resp_valid ? pat_inc : pat_count_q;
  assign max_hit  = (pat_next >= CNT_W'(MAX_PAT));

  // The first END of a run is the rpg seed cycle, so closing needs armed_q.
  always_comb begin
    state_d     = state_q;
    pat_count_d = pat_count_q;
    armed_d     = armed_q;
    to_flag_d   = to_flag_q;
    sig_load    = 1'b0;
    sig_en      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d     = ST_COMPRESS;
          sig_load    = 1'b1;
          pat_count_d = '0;
          armed_d     = 1'b0;
          to_flag_d   = 1'b0;
        end
      end
      ST_COMPRESS: begin
        sig_en      = bus.resp_valid;
        pat_count_d = pat_next;
        if (bus.resp_valid) begin
          armed_d = 1'b1;
        end
        if (bus.end_in && armed_q) begin
          state_d = ST_COMPARE;
        end else if (max_hit) begin
          to_flag_d = 1'b1;
          state_d   = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered and decoded from the next state.
  always_comb begin
    busy_d    = (state_d == ST_COMPRESS) || (state_d == ST_COMPARE);
    done_d    = (state_d == ST_DONE);
    timeout_d = (state_d == ST_DONE) ? to_flag_d : 1'b0;
    pass_d    = 1'b0;
    if (state_q == ST_COMPARE) begin
      pass_d = (sig == GOLDEN) && !to_flag_q;
    end else if ((state_q == ST_DONE) && (state_d == ST_DONE)) begin
      pass_d = pass_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pat_count_q <= '0;
      armed_q     <= 1'b0;
      to_flag_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_count_q <= pat_count_d;
      armed_q     <= armed_d;
      to_flag_q   <= to_flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.signature = sig;
  assign bus.pat_count = pat_count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_ora_misr.sv
// Directed bench for ora_misr (BITS=4, POLY=1001, SEED=0000, GOLDEN=0100):
// a vector table for the basic runs plus hand-written multi-cycle sequences.
module tb_ora_misr;

  typedef struct {
    logic       start;
    logic [3:0] resp;
    logic       valid;
    logic       end_in;
    logic [3:0] sig;
    logic [5:0] cnt;
    logic       busy;
    logic       done;
    logic       pass;
    logic       to;
  } vec_t;

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;
  vec_t vecs[$];

  ora_misr_if #(.BITS(4), .CNT_W(6)) bus ();

  ora_misr #(
    .BITS    (4),
    .POLY    (4'b1001),
    .SEED    (4'b0000),
    .GOLDEN  (4'b0100),
    .MAX_PAT (17),
    .CNT_W   (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] sig, input logic [5:0] cnt,
                          input logic busy, input logic done, input logic pass, input logic to);
    checkOutput({tag, ".signature"}, 32'(bus.signature), 32'(sig));
    checkOutput({tag, ".pat_count"}, 32'(bus.pat_count), 32'(cnt));
    checkOutput({tag, ".busy"},      32'(bus.busy),      32'(busy));
    checkOutput({tag, ".done"},      32'(bus.done),      32'(done));
    checkOutput({tag, ".pass"},      32'(bus.pass),      32'(pass));
    checkOutput({tag, ".timeout"},   32'(bus.timeout),   32'(to));
  endtask

  // Drive on the falling edge, then sample just after the next rising edge.
  task automatic applyStimulus(input logic start, input logic [3:0] resp,
                               input logic valid, input logic end_in);
    @(negedge clk);
    bus.start      = start;
    bus.resp       = resp;
    bus.resp_valid = valid;
    bus.end_in     = end_in;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic start, input logic [3:0] resp, input logic valid,
                        input logic end_in, input logic [3:0] sig, input logic [5:0] cnt,
                        input logic busy, input logic done, input logic pass, input logic to);
    vec_t v;
    v.start = start; v.resp = resp; v.valid = valid; v.end_in = end_in;
    v.sig = sig; v.cnt = cnt; v.busy = busy; v.done = done; v.pass = pass; v.to = to;
    vecs.push_back(v);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.resp       = 4'b0000;
    bus.resp_valid = 1'b0;
    bus.end_in     = 1'b0;

    // Run 1: 0001,0001,0000 -> 0001,1001,0100, golden match
    addVec(1, 4'b0000, 0, 0, 4'b0000, 6'd0, 1, 0, 0, 0);
    addVec(0, 4'b0001, 1, 0, 4'b0001, 6'd1, 1, 0, 0, 0);
    addVec(0, 4'b0001, 1, 0, 4'b1001, 6'd2, 1, 0, 0, 0);
    addVec(0, 4'b0000, 1, 1, 4'b0100, 6'd3, 1, 0, 0, 0);
    addVec(0, 4'b0000, 0, 0, 4'b0100, 6'd3, 0, 1, 1, 0);
    addVec(0, 4'b0000, 0, 0, 4'b0100, 6'd3, 0, 1, 1, 0);
    // Run 2: last response 0001 -> 0101, no match
    addVec(1, 4'b0000, 0, 0, 4'b0000, 6'd0, 1, 0, 0, 0);
    addVec(0, 4'b0001, 1, 0, 4'b0001, 6'd1, 1, 0, 0, 0);
    addVec(0, 4'b0001, 1, 0, 4'b1001, 6'd2, 1, 0, 0, 0);
    addVec(0, 4'b0001, 1, 1, 4'b0101, 6'd3, 1, 0, 0, 0);
    addVec(0, 4'b0000, 0, 0, 4'b0101, 6'd3, 0, 1, 0, 0);
    // Run 6: restart from DONE, gaps in resp_valid, start ignored in COMPRESS
    addVec(1, 4'b0000, 0, 0, 4'b0000, 6'd0, 1, 0, 0, 0);
    addVec(0, 4'b1111, 0, 0, 4'b0000, 6'd0, 1, 0, 0, 0);
    addVec(0, 4'b0001, 1, 0, 4'b0001, 6'd1, 1, 0, 0, 0);
    addVec(0, 4'b1010, 0, 0, 4'b0001, 6'd1, 1, 0, 0, 0);
    addVec(1, 4'b0000, 0, 0, 4'b0001, 6'd1, 1, 0, 0, 0);
    addVec(1, 4'b0001, 1, 0, 4'b1001, 6'd2, 1, 0, 0, 0);
    addVec(0, 4'b0000, 0, 1, 4'b1001, 6'd2, 1, 0, 0, 0);
    addVec(0, 4'b0000, 0, 0, 4'b1001, 6'd2, 0, 1, 0, 0);

    #1;
    checkAll("reset", 4'b0000, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].resp, vecs[i].valid, vecs[i].end_in);
      checkAll($sformatf("vec%0d", i), vecs[i].sig, vecs[i].cnt,
               vecs[i].busy, vecs[i].done, vecs[i].pass, vecs[i].to);
    end

    // end_in held high from the start cycle: seed-cycle END must be ignored
    applyStimulus(1, 4'b0000, 0, 1);
    checkAll("endHeld.start", 4'b0000, 6'd0, 1, 0, 0, 0);
    applyStimulus(0, 4'b0001, 1, 1);
    checkAll("endHeld.first", 4'b0001, 6'd1, 1, 0, 0, 0);
    applyStimulus(0, 4'b0001, 1, 1);
    checkAll("endHeld.close", 4'b1001, 6'd2, 1, 0, 0, 0);
    applyStimulus(0, 4'b0000, 0, 0);
    checkAll("endHeld.done", 4'b1001, 6'd2, 0, 1, 0, 0);

    // No END at all: timeout after the 17th compression
    applyStimulus(1, 4'b0000, 0, 0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 4'b0001, 1, 0);
      if (i == 15) begin
        checkOutput("timeout.cnt16", 32'(bus.pat_count), 32'd16);
        checkOutput("timeout.busy16", 32'(bus.busy), 32'd1);
      end
    end
    checkOutput("timeout.cnt17", 32'(bus.pat_count), 32'd17);
    checkOutput("timeout.notDoneYet", 32'(bus.done), 32'd0);
    checkOutput("timeout.noFlagYet", 32'(bus.timeout), 32'd0);
    applyStimulus(0, 4'b0000, 1, 0);
    checkOutput("timeout.done", 32'(bus.done), 32'd1);
    checkOutput("timeout.flag", 32'(bus.timeout), 32'd1);
    checkOutput("timeout.pass", 32'(bus.pass), 32'd0);
    checkOutput("timeout.cntHeld", 32'(bus.pat_count), 32'd17);
    applyStimulus(0, 4'b0000, 0, 0);
    checkOutput("timeout.flagHeld", 32'(bus.timeout), 32'd1);

    // END coinciding with the MAX_PAT hit: END wins, no timeout
    applyStimulus(1, 4'b0000, 0, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 4'b0000, 1, 0);
    end
    applyStimulus(0, 4'b0000, 1, 1);
    applyStimulus(0, 4'b0000, 0, 0);
    checkAll("endAtMax", 4'b0000, 6'd17, 0, 1, 0, 0);

    // Reset mid-run after two vectors
    applyStimulus(1, 4'b0000, 0, 0);
    applyStimulus(0, 4'b0001, 1, 0);
    applyStimulus(0, 4'b0001, 1, 0);
    checkAll("midRun.before", 4'b1001, 6'd2, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAll("midRun.reset", 4'b0000, 6'd0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 4'b0011, 1, 1);
    checkAll("midRun.idle", 4'b0000, 6'd0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
